// File: rtl/score_event_queue.sv
// score_event_queue: captures per-type scoring events into small pending
// counters and issues at most one BCD score increment per cycle. Each
// increment is scaled by a combo multiplier that rises for rapid hits.
//
// Ports:
//   clk           system clock
//   reset         asynchronous active-high reset
//   startOfFrame  one-cycle pulse per video frame (combo timebase)
//   evt_req[3:0]  one-cycle event strobes, bit k = event type k
//   hold          keep capturing but issue nothing
//   flush         discard queue and end combo
//   add_en        one-cycle strobe: add add_value to the score
//   add_value     BCD increment {tens,ones}, valid while add_en=1
//   combo         current multiplier 1..3
//   drop_cnt      events lost to a full queue, saturates at 255
module score_event_queue #(
  parameter int unsigned COMBO_FRAMES = 30,
  parameter int unsigned PEND_MAX     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic [3:0] evt_req,
  input  logic       hold,
  input  logic       flush,
  output logic       add_en,
  output logic [7:0] add_value,
  output logic [1:0] combo,
  output logic [7:0] drop_cnt
);

  localparam int unsigned NTYPES = 4;
  localparam int unsigned PW     = 2;
  localparam int unsigned TW     = $clog2(COMBO_FRAMES + 1);
  localparam int unsigned DW     = 8;

  logic [NTYPES-1:0][PW-1:0] pend, pend_nxt;
  logic [TW-1:0]             timer;
  logic                      iss_v;
  logic [1:0]                iss_k;
  logic [1:0]                combo_new;
  logic [7:0]                val_new;
  logic [2:0]                ndrop;
  logic [DW:0]               drop_sum;
  logic [DW-1:0]             drop_nxt;
  logic                      win_open;

  // BCD increment for event type k at multiplier m
  function automatic logic [7:0] bcd_value(input logic [1:0] k, input logic [1:0] m);
    logic [7:0] v;
    case ({k, m})
      4'b00_01: v = 8'h01;
      4'b00_10: v = 8'h02;
      4'b00_11: v = 8'h03;
      4'b01_01: v = 8'h05;
      4'b01_10: v = 8'h10;
      4'b01_11: v = 8'h15;
      4'b10_01: v = 8'h10;
      4'b10_10: v = 8'h20;
      4'b10_11: v = 8'h30;
      4'b11_01: v = 8'h25;
      4'b11_10: v = 8'h50;
      4'b11_11: v = 8'h75;
      default:  v = 8'h00;
    endcase
    return v;
  endfunction

  assign win_open = (timer < TW'(COMBO_FRAMES));

  // Issue selection, combo step, capture/drop bookkeeping
  always_comb begin
    iss_v     = 1'b0;
    iss_k     = 2'd0;
    combo_new = 2'd1;
    val_new   = 8'h00;
    pend_nxt  = pend;
    ndrop     = 3'd0;
    drop_sum  = '0;
    drop_nxt  = drop_cnt;

    // Ascending scan so the highest non-empty type wins
    for (int k = 0; k < int'(NTYPES); k++) begin
      if (pend[k] != '0) begin
        iss_v = !hold && !flush;
        iss_k = 2'(k);
      end
    end

    if (win_open) combo_new = (combo == 2'd3) ? 2'd3 : combo + 2'd1;
    val_new = bcd_value(iss_k, combo_new);

    // Capture and issue of the same type in one cycle cancel out
    for (int k = 0; k < int'(NTYPES); k++) begin
      if (evt_req[k] && !(iss_v && iss_k == 2'(k))) begin
        if (pend[k] == PW'(PEND_MAX)) ndrop = ndrop + 3'd1;
        else                          pend_nxt[k] = pend[k] + PW'(1);
      end else if (!evt_req[k] && iss_v && iss_k == 2'(k)) begin
        pend_nxt[k] = pend[k] - PW'(1);
      end
    end

    drop_sum = {1'b0, drop_cnt} + (DW+1)'(ndrop);
    drop_nxt = drop_sum[DW] ? {DW{1'b1}} : drop_sum[DW-1:0];
  end

  // State and registered outputs; flush overrides capture and issue
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend      <= '0;
      add_en    <= 1'b0;
      add_value <= 8'h00;
      combo     <= 2'd1;
      timer     <= TW'(COMBO_FRAMES);
      drop_cnt  <= '0;
    end else if (flush) begin
      pend   <= '0;
      add_en <= 1'b0;
      combo  <= 2'd1;
      timer  <= TW'(COMBO_FRAMES);
    end else begin
      pend     <= pend_nxt;
      drop_cnt <= drop_nxt;
      add_en   <= iss_v;
      if (iss_v) begin
        combo     <= combo_new;
        add_value <= val_new;
        timer     <= '0;
      end else begin
        if (startOfFrame && win_open) timer <= timer + TW'(1);
        // Expired window shows x1 on the combo output
        if (!win_open) combo <= 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_score_event_queue.sv
// Directed bench for score_event_queue with hand-computed expectations.
module tb_score_event_queue;

  localparam int unsigned CF = 30;

  logic       clk;
  logic       reset;
  logic       startOfFrame;
  logic [3:0] evt_req;
  logic       hold;
  logic       flush;
  logic       add_en;
  logic [7:0] add_value;
  logic [1:0] combo;
  logic [7:0] drop_cnt;

  int total;
  int bad;

  score_event_queue #(.COMBO_FRAMES(CF), .PEND_MAX(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (startOfFrame),
    .evt_req      (evt_req),
    .hold         (hold),
    .flush        (flush),
    .add_en       (add_en),
    .add_value    (add_value),
    .combo        (combo),
    .drop_cnt     (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      tick();
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  // Strobe one event set and return after the cycle where add_en should rise
  task automatic hit(input logic [3:0] ev);
    evt_req = ev;
    tick();
    evt_req = 4'b0000;
    tick();
  endtask

  logic [7:0] exp_seq [4];
  int         pulses;

  initial begin
    total = 0;
    bad   = 0;
    reset        = 1'b1;
    startOfFrame = 1'b0;
    evt_req      = 4'b0000;
    hold         = 1'b0;
    flush        = 1'b0;
    tick();
    tick();
    chk("rst_add_en", 32'(add_en), 32'd0);
    chk("rst_add_value", 32'(add_value), 32'h00);
    chk("rst_combo", 32'(combo), 32'd1);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    reset = 1'b0;
    tick();

    // 1: single type0 event, add_en two cycles after the strobe
    evt_req = 4'b0001;
    tick();
    evt_req = 4'b0000;
    chk("t1_n1_en", 32'(add_en), 32'd0);
    tick();
    chk("t1_en", 32'(add_en), 32'd1);
    chk("t1_val", 32'(add_value), 32'h01);
    chk("t1_combo", 32'(combo), 32'd1);
    tick();
    chk("t1_single", 32'(add_en), 32'd0);

    // 2: all four types at once, priority 3,2,1,0 with rising combo
    do_flush();
    exp_seq = '{8'h25, 8'h20, 8'h15, 8'h03};
    hit(4'b1111);
    for (int i = 0; i < 4; i++) begin
      chk("t2_en", 32'(add_en), 32'd1);
      chk("t2_val", 32'(add_value), 32'(exp_seq[i]));
      tick();
    end
    chk("t2_end", 32'(add_en), 32'd0);
    chk("t2_combo", 32'(combo), 32'd3);
    // window expiry brings combo back to x1
    frames(CF);
    chk("t2_expire", 32'(combo), 32'd1);

    // 3: combo window boundaries for type1
    do_flush();
    hit(4'b0010);
    chk("t3_a_val", 32'(add_value), 32'h05);
    frames(CF - 1);
    hit(4'b0010);
    chk("t3_in_win_val", 32'(add_value), 32'h10);
    chk("t3_in_win_combo", 32'(combo), 32'd2);
    frames(CF);
    chk("t3_exp_combo", 32'(combo), 32'd1);
    hit(4'b0010);
    chk("t3_at_cf_val", 32'(add_value), 32'h05);
    frames(CF + 1);
    hit(4'b0010);
    chk("t3_b_en", 32'(add_en), 32'd1);
    chk("t3_b_val", 32'(add_value), 32'h05);
    chk("t3_b_combo", 32'(combo), 32'd1);

    // 4: hold with five type0 strobes -> three queued, two dropped
    do_flush();
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      evt_req = 4'b0001;
      tick();
      chk("t4_hold_en", 32'(add_en), 32'd0);
    end
    evt_req = 4'b0000;
    chk("t4_drop", 32'(drop_cnt), 32'd2);
    hold = 1'b0;
    exp_seq = '{8'h01, 8'h02, 8'h03, 8'h00};
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i < 3) chk("t4_b2b_en", 32'(add_en), 32'd1);
      if (add_en) begin
        if (pulses < 3) chk("t4_val", 32'(add_value), 32'(exp_seq[pulses]));
        pulses++;
      end
    end
    chk("t4_pulses", 32'(pulses), 32'd3);

    // capture and issue of the same full type: no drop, queue stays full
    do_flush();
    hold = 1'b1;
    evt_req = 4'b0001;
    tick();
    tick();
    tick();
    hold = 1'b0;
    tick();
    evt_req = 4'b0000;
    pulses = 32'(add_en);
    for (int i = 0; i < 6; i++) begin
      tick();
      pulses += 32'(add_en);
    end
    chk("sim_pulses", 32'(pulses), 32'd4);
    chk("sim_drop", 32'(drop_cnt), 32'd2);

    // drop counter saturation
    hold = 1'b1;
    evt_req = 4'b1111;
    for (int i = 0; i < 70; i++) tick();
    evt_req = 4'b0000;
    chk("sat_drop", 32'(drop_cnt), 32'd255);
    hold = 1'b0;

    // 5: flush with three pending at combo x3
    do_flush();
    hit(4'b1111);
    tick();
    tick();
    tick();
    chk("t5_combo3", 32'(combo), 32'd3);
    hold = 1'b1;
    evt_req = 4'b0001;
    tick();
    tick();
    tick();
    flush = 1'b1;
    evt_req = 4'b1111;
    tick();
    flush = 1'b0;
    evt_req = 4'b0000;
    chk("t5_en", 32'(add_en), 32'd0);
    chk("t5_combo", 32'(combo), 32'd1);
    chk("t5_drop", 32'(drop_cnt), 32'd255);
    hold = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      pulses += 32'(add_en);
    end
    chk("t5_no_issue", 32'(pulses), 32'd0);

    // 6: async reset while add_en is high
    hit(4'b1111);
    tick();
    chk("t6_pre_en", 32'(add_en), 32'd1);
    chk("t6_pre_combo", 32'(combo), 32'd2);
    reset = 1'b1;
    #1;
    chk("t6_async_en", 32'(add_en), 32'd0);
    chk("t6_async_combo", 32'(combo), 32'd1);
    chk("t6_async_drop", 32'(drop_cnt), 32'd0);
    tick();
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      pulses += 32'(add_en);
    end
    chk("t6_pend_cleared", 32'(pulses), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
